// File: rtl/z_tile_sequencer.sv
// z_tile_sequencer: per-tile depth-buffer clear, triangle handshake and raster scan
// The scan position is one ADDR_W counter whose low bits are the column and high bits the row.
module z_tile_sequencer #(
    parameter int TILE_W_LOG2 = 5,
    parameter int TILE_H_LOG2 = 5,
    parameter int ADDR_W      = 10
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   tile_start,
    input  logic                   tile_clear_en,
    output logic                   tile_busy,
    output logic                   tile_done,
    output logic                   clear_z,
    input  logic                   clear_done,
    input  logic                   tri_valid,
    input  logic                   tri_last,
    output logic                   tri_ready,
    input  logic                   scan_stall,
    output logic                   pix_valid,
    output logic [TILE_W_LOG2-1:0] pix_x,
    output logic [TILE_H_LOG2-1:0] pix_y,
    output logic [ADDR_W-1:0]      z_buff_addr,
    output logic [15:0]            tri_count
);
    typedef enum logic [2:0] {IDLE, CLEAR_REQ, CLEAR_WAIT, WAIT_TRI, SCAN, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] pos;
    logic last_q;
    assign pix_x       = pos[TILE_W_LOG2-1:0];
    assign pix_y       = pos[ADDR_W-1:TILE_W_LOG2];
    assign z_buff_addr = pos;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = tile_start ? (tile_clear_en ? CLEAR_REQ : WAIT_TRI) : IDLE;
            CLEAR_REQ:  state_nx = CLEAR_WAIT;
            CLEAR_WAIT: state_nx = clear_done ? WAIT_TRI : CLEAR_WAIT;
            WAIT_TRI:   state_nx = tri_valid ? SCAN : WAIT_TRI;
            SCAN:       state_nx = (!scan_stall && &pos) ? (last_q ? DONE : WAIT_TRI) : SCAN;
            DONE:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end
    always_comb begin
        tile_busy = state != IDLE;
        tile_done = state == DONE;
        clear_z   = state == CLEAR_REQ;
        tri_ready = state == WAIT_TRI;
        pix_valid = state == SCAN;
    end
    // The position wraps to zero on the final pixel, so it is already cleared for the next scan.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pos       <= '0;
            tri_count <= '0;
            last_q    <= 1'b0;
        end else begin
            if (state == IDLE && tile_start) begin
                pos       <= '0;
                tri_count <= '0;
            end
            if (state == WAIT_TRI && tri_valid) begin
                pos       <= '0;
                last_q    <= tri_last;
                tri_count <= tri_count + {15'd0, ~&tri_count};
            end
            if (state == SCAN && !scan_stall) pos <= pos + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_z_tile_sequencer.sv
// tb_z_tile_sequencer: directed tests for the tile sequencer
module tb_z_tile_sequencer;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tile_start = 1'b0;
    logic       tile_clear_en = 1'b0;
    logic       tile_busy;
    logic       tile_done;
    logic       clear_z;
    logic       clear_done = 1'b0;
    logic       tri_valid = 1'b0;
    logic       tri_last = 1'b0;
    logic       tri_ready;
    logic       scan_stall = 1'b0;
    logic       pix_valid;
    logic [4:0] pix_x;
    logic [4:0] pix_y;
    logic [9:0] z_buff_addr;
    logic [15:0] tri_count;
    int total = 0;
    int bad = 0;
    int clr_cnt = 0;
    int done_cnt = 0;

    z_tile_sequencer dut (
        .clock(clock), .reset_n(reset_n), .tile_start(tile_start), .tile_clear_en(tile_clear_en),
        .tile_busy(tile_busy), .tile_done(tile_done), .clear_z(clear_z), .clear_done(clear_done),
        .tri_valid(tri_valid), .tri_last(tri_last), .tri_ready(tri_ready), .scan_stall(scan_stall),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .z_buff_addr(z_buff_addr),
        .tri_count(tri_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        clr_cnt  <= clr_cnt + int'(clear_z);
        done_cnt <= done_cnt + int'(tile_done);
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic start_tile(input bit clr);
        tile_start = 1'b1;
        tile_clear_en = clr;
        tick();
        tile_start = 1'b0;
        tile_clear_en = 1'b0;
    endtask

    task automatic send_tri(input bit last);
        tri_valid = 1'b1;
        tri_last = last;
        tick();
        tri_valid = 1'b0;
        tri_last = 1'b0;
    endtask

    // Runs one scan against an expected-position model; optional stall window and stray start/triangle pulse.
    task automatic scan(input int stall_at, input int stall_len, input int poke_at, output int n, output int errs);
        int exp_a;
        int stalls;
        bit st;
        exp_a = 0;
        stalls = 0;
        n = 0;
        errs = 0;
        while (pix_valid === 1'b1 && n < 5000) begin
            if (z_buff_addr !== 10'(exp_a) || pix_x !== 5'(exp_a) || pix_y !== 5'(exp_a >> 5) ||
                tri_ready !== 1'b0 || tile_busy !== 1'b1 || tile_done !== 1'b0)
                errs++;
            st = (exp_a == stall_at && stalls < stall_len);
            if (st) stalls++;
            scan_stall = st;
            tile_start = (n == poke_at);
            tile_clear_en = (n == poke_at);
            tri_valid = (n == poke_at);
            tri_last = (n == poke_at);
            if (!st) exp_a++;
            n++;
            tick();
        end
        scan_stall = 1'b0;
        tile_start = 1'b0;
        tile_clear_en = 1'b0;
        tri_valid = 1'b0;
        tri_last = 1'b0;
    endtask

    task automatic test_reset();
        int k;
        int d0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        total++;
        if ({tile_busy, tile_done, clear_z, tri_ready, pix_valid} !== 5'b0 || z_buff_addr !== 10'd0 || tri_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b clr=%b rdy=%b pv=%b addr=%0d cnt=%0d, required all 0",
                     tile_busy, tile_done, clear_z, tri_ready, pix_valid, z_buff_addr, tri_count);
        end
        start_tile(1'b0);
        send_tri(1'b0);
        k = 0;
        while (z_buff_addr !== 10'd103 && k < 2000) begin
            tick();
            k++;
        end
        total++;
        if (pix_x !== 5'd7 || pix_y !== 5'd3 || pix_valid !== 1'b1) begin
            bad++;
            $display("FAIL reach_x7_y3: x=%0d y=%0d pv=%b, required x=7 y=3 pv=1", pix_x, pix_y, pix_valid);
        end
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        total++;
        if (pix_valid !== 1'b0 || tile_busy !== 1'b0 || tri_count !== 16'd0 || z_buff_addr !== 10'd0) begin
            bad++;
            $display("FAIL reset_mid_scan: pv=%b busy=%b cnt=%0d addr=%0d, required 0 0 0 0",
                     pix_valid, tile_busy, tri_count, z_buff_addr);
        end
        @(negedge clock);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        total++;
        if (done_cnt !== d0 || tile_busy !== 1'b0 || tile_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done: done_pulses=%0d busy=%b, required 0 pulses busy=0", done_cnt - d0, tile_busy);
        end
    endtask

    task automatic test_clear();
        int c0;
        int busy_bad;
        int n;
        int e;
        c0 = clr_cnt;
        start_tile(1'b1);
        total++;
        if (clear_z !== 1'b1) begin
            bad++;
            $display("FAIL clear_req: clear_z=%b, required 1", clear_z);
        end
        busy_bad = 0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (tile_busy !== 1'b1 || tri_ready !== 1'b0) busy_bad++;
        end
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        total++;
        if (tri_ready !== 1'b1 || tile_busy !== 1'b1) begin
            bad++;
            $display("FAIL clear_ready: tri_ready=%b busy=%b, required 1 1", tri_ready, tile_busy);
        end
        total++;
        if (busy_bad !== 0) begin
            bad++;
            $display("FAIL clear_wait: bad_cycles=%0d, required 0", busy_bad);
        end
        total++;
        if (clr_cnt - c0 !== 1) begin
            bad++;
            $display("FAIL clear_pulses: got %0d, required 1", clr_cnt - c0);
        end
        send_tri(1'b1);
        scan(-1, 0, -1, n, e);
        total++;
        if (n !== 1024 || e !== 0 || tile_done !== 1'b1) begin
            bad++;
            $display("FAIL clear_tile_scan: len=%0d errs=%0d done=%b, required 1024 0 1", n, e, tile_done);
        end
        tick();
    endtask

    task automatic test_no_clear();
        int c0;
        int d0;
        int n;
        int e;
        c0 = clr_cnt;
        d0 = done_cnt;
        start_tile(1'b0);
        total++;
        if (tri_ready !== 1'b1) begin
            bad++;
            $display("FAIL noclr_ready: tri_ready=%b, required 1", tri_ready);
        end
        send_tri(1'b1);
        scan(-1, 0, -1, n, e);
        total++;
        if (n !== 1024 || e !== 0) begin
            bad++;
            $display("FAIL noclr_scan: len=%0d errs=%0d, required 1024 0", n, e);
        end
        total++;
        if (tile_done !== 1'b1 || tri_count !== 16'd1) begin
            bad++;
            $display("FAIL noclr_done: done=%b cnt=%0d, required 1 1", tile_done, tri_count);
        end
        tick();
        total++;
        if (clr_cnt !== c0 || done_cnt - d0 !== 1 || tile_busy !== 1'b0) begin
            bad++;
            $display("FAIL noclr_end: clears=%0d dones=%0d busy=%b, required 0 1 0", clr_cnt - c0, done_cnt - d0, tile_busy);
        end
    endtask

    task automatic test_multi_tri();
        int d0;
        int n;
        int e;
        int n_tot;
        int e_tot;
        int gap_bad;
        d0 = done_cnt;
        n_tot = 0;
        e_tot = 0;
        gap_bad = 0;
        start_tile(1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            if (tri_ready !== 1'b1 || tile_done !== 1'b0) gap_bad++;
            send_tri(k == 2);
            scan(-1, 0, -1, n, e);
            n_tot += n;
            e_tot += e;
        end
        total++;
        if (n_tot !== 3072 || e_tot !== 0 || gap_bad !== 0) begin
            bad++;
            $display("FAIL multi_scan: len=%0d errs=%0d gap_errs=%0d, required 3072 0 0", n_tot, e_tot, gap_bad);
        end
        total++;
        if (tri_count !== 16'd3 || tile_done !== 1'b1) begin
            bad++;
            $display("FAIL multi_done: cnt=%0d done=%b, required 3 1", tri_count, tile_done);
        end
        tick();
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL multi_pulses: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_stall();
        int n;
        int e;
        start_tile(1'b0);
        send_tri(1'b1);
        scan(37, 4, -1, n, e);
        total++;
        if (n !== 1028 || e !== 0) begin
            bad++;
            $display("FAIL stall_scan: len=%0d errs=%0d, required 1028 0", n, e);
        end
        total++;
        if (tile_done !== 1'b1) begin
            bad++;
            $display("FAIL stall_done: done=%b, required 1", tile_done);
        end
        tick();
    endtask

    task automatic test_ignored();
        int c0;
        int d0;
        int n;
        int e;
        d0 = done_cnt;
        start_tile(1'b0);
        c0 = clr_cnt;
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        tick();
        total++;
        if (tri_ready !== 1'b1 || tile_busy !== 1'b1 || clr_cnt !== c0) begin
            bad++;
            $display("FAIL stray_clear_done: rdy=%b busy=%b clears=%0d, required 1 1 0", tri_ready, tile_busy, clr_cnt - c0);
        end
        send_tri(1'b1);
        scan(-1, 0, 10, n, e);
        total++;
        if (n !== 1024 || e !== 0) begin
            bad++;
            $display("FAIL start_in_scan: len=%0d errs=%0d, required 1024 0", n, e);
        end
        total++;
        if (tri_count !== 16'd1 || tile_done !== 1'b1) begin
            bad++;
            $display("FAIL tri_in_scan: cnt=%0d done=%b, required 1 1", tri_count, tile_done);
        end
        tick();
        tick();
        total++;
        if (tile_busy !== 1'b0 || clr_cnt !== c0 || done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL no_queue: busy=%b clears=%0d dones=%0d, required 0 0 1", tile_busy, clr_cnt - c0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_no_clear();
        test_multi_tri();
        test_stall();
        test_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
